// File: rtl/branch_predict_ctrl.sv
// ID-stage control decode, load-use hazard and 2-bit bimodal beq predictor.
// Optional BP_STATS_EN adds branch/mispredict statistics counters.
module branch_predict_ctrl #(
  parameter int         BHT_IDX_W = 4,
  parameter int         PC_W      = 32,
  parameter logic [1:0] CNT_INIT  = 2'b01
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [PC_W-1:0] if_pc,
  input  logic            if_is_beq,
  input  logic            id_valid,
  input  logic [5:0]      id_opcode,
  input  logic [PC_W-1:0] id_pc,
  input  logic            id_equal,
  input  logic [4:0]      id_rs,
  input  logic [4:0]      id_rt,
  input  logic            idex_memread,
  input  logic [4:0]      idex_rt,
  output logic [7:0]      ctrl,
  output logic [1:0]      sel_pc,
  output logic            recover_taken,
  output logic            if_flush,
  output logic            pc_write,
  output logic            ifid_write
`ifdef BP_STATS_EN
  ,
  output logic [15:0]     stat_branches,
  output logic [15:0]     stat_mispredicts
`endif
);

  localparam int N = 1 << BHT_IDX_W;

  logic [1:0] cnt_q [N];
  logic [1:0] cnt_d [N];
  logic       id_pred_q, id_pred_d;

  logic [BHT_IDX_W-1:0] if_idx, id_idx;
  logic                 stall, is_jmp, is_beq;
  logic                 resolve, mispred, pred;
  logic                 unused_pc;

  assign if_idx = if_pc[BHT_IDX_W+1:2];
  assign id_idx = id_pc[BHT_IDX_W+1:2];
  assign unused_pc = ^{if_pc[PC_W-1:BHT_IDX_W+2], if_pc[1:0],
                       id_pc[PC_W-1:BHT_IDX_W+2], id_pc[1:0]};

  assign stall = id_valid & idex_memread & (idex_rt != 5'd0)
               & ((idex_rt == id_rs) | (idex_rt == id_rt));
  assign is_jmp  = id_valid & (id_opcode == 6'b000010);
  assign is_beq  = id_valid & (id_opcode == 6'b000100);
  assign resolve = is_beq & ~stall;
  assign mispred = resolve & (id_equal != id_pred_q);
  // Lookup reads the registered table, so a same-index update is not seen.
  assign pred    = if_is_beq & cnt_q[if_idx][1];

  always_comb begin
    ctrl = 8'h00;
    if (id_valid && !stall) begin
      unique case (id_opcode)
        6'b000000: ctrl = 8'b11010000;
        6'b000010: ctrl = 8'b00111000;
        6'b000100: ctrl = 8'b00001000;
        6'b001000: ctrl = 8'b01100000;
        6'b100011: ctrl = 8'b01100011;
        6'b101011: ctrl = 8'b00100100;
        default:   ctrl = 8'h00;
      endcase
    end
  end

  always_comb begin
    sel_pc        = 2'b00;
    pc_write      = 1'b1;
    ifid_write    = 1'b1;
    if_flush      = 1'b0;
    recover_taken = 1'b0;
    if (stall) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
    end else if (is_jmp) begin
      sel_pc   = 2'b10;
      if_flush = 1'b1;
    end else if (mispred) begin
      sel_pc        = 2'b11;
      recover_taken = id_equal;
      if_flush      = 1'b1;
    end else if (pred) begin
      sel_pc = 2'b01;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (resolve) begin
      if (id_equal && cnt_q[id_idx] != 2'd3)
        cnt_d[id_idx] = cnt_q[id_idx] + 2'd1;
      else if (!id_equal && cnt_q[id_idx] != 2'd0)
        cnt_d[id_idx] = cnt_q[id_idx] - 2'd1;
    end
    id_pred_d = id_pred_q;
    if (if_flush)        id_pred_d = 1'b0;
    else if (ifid_write) id_pred_d = pred;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) cnt_q[i] <= CNT_INIT;
      id_pred_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      id_pred_q <= id_pred_d;
    end
  end

`ifdef BP_STATS_EN
  logic [15:0] stat_br_q, stat_br_d;
  logic [15:0] stat_mp_q, stat_mp_d;

  always_comb begin
    stat_br_d = stat_br_q + {15'd0, resolve};
    stat_mp_d = stat_mp_q + {15'd0, mispred};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stat_br_q <= 16'd0;
      stat_mp_q <= 16'd0;
    end else begin
      stat_br_q <= stat_br_d;
      stat_mp_q <= stat_mp_d;
    end
  end

  assign stat_branches    = stat_br_q;
  assign stat_mispredicts = stat_mp_q;
`endif

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Bench for branch_predict_ctrl: directed scenarios plus randomized run
// against a table/array reference model. Honours BP_STATS_EN.
module tb_branch_predict_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc, id_pc;
  logic        if_is_beq, id_valid, id_equal, idex_memread;
  logic [5:0]  id_opcode;
  logic [4:0]  id_rs, id_rt, idex_rt;
  logic [7:0]  ctrl;
  logic [1:0]  sel_pc;
  logic        recover_taken, if_flush, pc_write, ifid_write;
`ifdef BP_STATS_EN
  logic [15:0] stat_branches, stat_mispredicts;
`endif

  branch_predict_ctrl dut (
    .clk(clk), .rst(rst), .if_pc(if_pc), .if_is_beq(if_is_beq),
    .id_valid(id_valid), .id_opcode(id_opcode), .id_pc(id_pc),
    .id_equal(id_equal), .id_rs(id_rs), .id_rt(id_rt),
    .idex_memread(idex_memread), .idex_rt(idex_rt),
    .ctrl(ctrl), .sel_pc(sel_pc), .recover_taken(recover_taken),
    .if_flush(if_flush), .pc_write(pc_write), .ifid_write(ifid_write)
`ifdef BP_STATS_EN
    , .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  int bht [16];
  bit mpred;
  int m_br, m_mp;
  // model outputs for current inputs
  logic [7:0] e_ctrl;
  logic [1:0] e_sel;
  bit e_rec, e_flush, e_pcw, e_ifw, e_pred, e_res, e_mis;

  function automatic logic [7:0] ctrl_of(input logic [5:0] op);
    case (op)
      6'd0:  return 8'b11010000;
      6'd2:  return 8'b00111000;
      6'd4:  return 8'b00001000;
      6'd8:  return 8'b01100000;
      6'd35: return 8'b01100011;
      6'd43: return 8'b00100100;
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_eval();
    bit st;
    st = id_valid && idex_memread && idex_rt != 0
         && (idex_rt == id_rs || idex_rt == id_rt);
    e_pred = if_is_beq && bht[if_pc[5:2]] >= 2;
    e_ctrl = (id_valid && !st) ? ctrl_of(id_opcode) : 8'h00;
    e_pcw = !st; e_ifw = !st;
    e_flush = 0; e_rec = 0; e_sel = 0; e_res = 0; e_mis = 0;
    if (!st) begin
      e_res = id_valid && id_opcode == 6'd4;
      e_mis = e_res && (id_equal != mpred);
      if (id_valid && id_opcode == 6'd2) begin
        e_sel = 2; e_flush = 1;
      end else if (e_mis) begin
        e_sel = 3; e_flush = 1; e_rec = id_equal;
      end else if (e_pred) begin
        e_sel = 1;
      end
    end
  endtask

  task automatic model_clk();
    int k;
    if (!rst) begin
      foreach (bht[i]) bht[i] = 1;
      mpred = 0; m_br = 0; m_mp = 0;
    end else begin
      if (e_res) begin
        k = id_pc[5:2];
        bht[k] = id_equal ? (bht[k] == 3 ? 3 : bht[k] + 1)
                          : (bht[k] == 0 ? 0 : bht[k] - 1);
        m_br = (m_br + 1) % 65536;
        if (e_mis) m_mp = (m_mp + 1) % 65536;
      end
      if (e_flush) mpred = 0;
      else if (e_ifw) mpred = e_pred;
    end
  endtask

  task automatic tick();
    model_eval();
    @(posedge clk);
    model_clk();
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 1; if_pc = 0; if_is_beq = 0; id_valid = 0; id_opcode = 0;
    id_pc = 0; id_equal = 0; id_rs = 0; id_rt = 0;
    idex_memread = 0; idex_rt = 0;
  endtask

  task automatic id_beq(input logic [31:0] pc, input logic eq);
    id_valid = 1; id_opcode = 6'd4; id_pc = pc; id_equal = eq;
  endtask

  task automatic test_reset();
    idle(); rst = 0;
    @(negedge clk); tick(); tick();
    rst = 1; #1;
    checks++;
    if (ctrl !== 8'h00) begin
      errors++; $display("FAIL reset_ctrl got %h exp 00", ctrl);
    end
    checks++;
    if (sel_pc !== 2'b00) begin
      errors++; $display("FAIL reset_sel got %b exp 00", sel_pc);
    end
    checks++;
    if ({pc_write, ifid_write, if_flush, recover_taken} !== 4'b1100) begin
      errors++;
      $display("FAIL reset_flags got %b exp 1100",
               {pc_write, ifid_write, if_flush, recover_taken});
    end
    tick();
  endtask

  task automatic test_predict_init();
    idle(); if_pc = 32'h40; if_is_beq = 1; #1;
    checks++;
    if (sel_pc !== 2'b00) begin
      errors++; $display("FAIL init_pred got %b exp 00", sel_pc);
    end
    tick();
  endtask

  task automatic test_train();
    idle(); id_beq(32'h40, 1); #1;
    checks++;
    if ({sel_pc, recover_taken, if_flush} !== 4'b1111) begin
      errors++;
      $display("FAIL train_first got %b exp 1111",
               {sel_pc, recover_taken, if_flush});
    end
    tick();
    id_beq(32'h40, 1); #1;
    checks++;
    if (sel_pc !== 2'b11) begin
      errors++; $display("FAIL train_second got %b exp 11", sel_pc);
    end
    tick();
    idle(); if_pc = 32'h40; if_is_beq = 1; #1;
    checks++;
    if (sel_pc !== 2'b01) begin
      errors++; $display("FAIL train_pred got %b exp 01", sel_pc);
    end
    tick();
    idle(); id_beq(32'h40, 1); #1;
    checks++;
    if ({sel_pc, if_flush} !== 3'b000) begin
      errors++;
      $display("FAIL train_correct got %b exp 000", {sel_pc, if_flush});
    end
    tick();
  endtask

  task automatic test_stall();
    idle(); idex_memread = 1; idex_rt = 5; id_rs = 5;
    id_beq(32'h44, 1); if_pc = 32'h40; if_is_beq = 1; #1;
    checks++;
    if ({pc_write, ifid_write, ctrl, sel_pc, if_flush} !== 13'd0) begin
      errors++;
      $display("FAIL stall_out got %b exp 0",
               {pc_write, ifid_write, ctrl, sel_pc, if_flush});
    end
    tick();
    idex_memread = 0; #1;
    checks++;
    if ({sel_pc, recover_taken, if_flush} !== {e_sel_now(), 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL stall_resolve got %b exp 1111",
               {sel_pc, recover_taken, if_flush});
    end
    tick();
    idle(); if_pc = 32'h44; if_is_beq = 1; #1;
    checks++;
    if (sel_pc !== 2'b01) begin
      errors++; $display("FAIL stall_counter got %b exp 01", sel_pc);
    end
    tick();
  endtask

  function automatic logic [1:0] e_sel_now();
    return 2'b11;
  endfunction

  task automatic test_jump();
    idle(); if_pc = 32'h40; if_is_beq = 1;
    id_valid = 1; id_opcode = 6'd2; #1;
    checks++;
    if ({sel_pc, if_flush, ctrl} !== {2'b10, 1'b1, 8'b00111000}) begin
      errors++;
      $display("FAIL jump got %b exp 10100111000", {sel_pc, if_flush, ctrl});
    end
    tick();
    idle(); id_beq(32'h50, 0); #1;
    checks++;
    if (sel_pc !== 2'b00) begin
      errors++; $display("FAIL jump_pred_cleared got %b exp 00", sel_pc);
    end
    tick();
  endtask

  task automatic test_saturate();
    idle(); id_beq(32'h48, 0); tick(); tick();
    if_pc = 32'h48; if_is_beq = 1; #1;
    checks++;
    if ({sel_pc, if_flush} !== 3'b000) begin
      errors++; $display("FAIL sat_low got %b exp 000", {sel_pc, if_flush});
    end
    tick();
    idle(); if_pc = 32'h40; if_is_beq = 1; tick();
    id_beq(32'h40, 1); #1;
    checks++;
    if ({sel_pc, if_flush} !== 3'b010) begin
      errors++; $display("FAIL sat_high got %b exp 010", {sel_pc, if_flush});
    end
    tick();
    idle(); id_beq(32'h4C, 1); tick();
    idle(); id_beq(32'h4C, 0); if_pc = 32'h4C; if_is_beq = 1; #1;
    checks++;
    if (sel_pc !== 2'b01) begin
      errors++; $display("FAIL same_idx_old got %b exp 01", sel_pc);
    end
    tick();
    idle(); if_pc = 32'h4C; if_is_beq = 1; #1;
    checks++;
    if (sel_pc !== 2'b00) begin
      errors++; $display("FAIL same_idx_new got %b exp 00", sel_pc);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    idle(); idex_memread = 1; idex_rt = 3; id_rt = 3;
    id_beq(32'h40, 0); rst = 0; tick();
    idle(); if_pc = 32'h40; if_is_beq = 1; #1;
    checks++;
    if (sel_pc !== 2'b00) begin
      errors++; $display("FAIL rst_mid_bht got %b exp 00", sel_pc);
    end
    tick();
  endtask

  task automatic test_random();
    logic [5:0] ops [7];
    ops = '{6'd0, 6'd2, 6'd4, 6'd4, 6'd8, 6'd35, 6'd43};
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 40) != 0);
      if_pc = $urandom; if_is_beq = $urandom_range(0, 1);
      id_valid = ($urandom_range(0, 5) != 0);
      id_opcode = ($urandom_range(0, 9) == 0) ? 6'($urandom)
                                              : ops[$urandom_range(0, 6)];
      id_pc = $urandom; id_equal = $urandom_range(0, 1);
      id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
      idex_memread = ($urandom_range(0, 2) == 0);
      idex_rt = 5'($urandom_range(0, 3));
      #1; model_eval();
      checks++;
      if ({ctrl, sel_pc, recover_taken, if_flush, pc_write, ifid_write} !==
          {e_ctrl, e_sel, e_rec, e_flush, e_pcw, e_ifw}) begin
        errors++;
        $display("FAIL random[%0d] got %b exp %b", n,
                 {ctrl, sel_pc, recover_taken, if_flush, pc_write, ifid_write},
                 {e_ctrl, e_sel, e_rec, e_flush, e_pcw, e_ifw});
      end
`ifdef BP_STATS_EN
      checks++;
      if ({stat_branches, stat_mispredicts} !== {16'(m_br), 16'(m_mp)}) begin
        errors++;
        $display("FAIL random_stats[%0d] got %h/%h exp %h/%h", n,
                 stat_branches, stat_mispredicts, m_br, m_mp);
      end
`endif
      tick();
    end
  endtask

`ifdef BP_STATS_EN
  task automatic test_stats_wrap();
    idle(); rst = 0; tick();
    idle(); id_beq(32'h60, 1);
    for (int n = 0; n < 65536; n++) tick();
    checks++;
    if (stat_mispredicts !== 16'd0 || m_mp != 0) begin
      errors++;
      $display("FAIL stats_wrap got %h exp 0000", stat_mispredicts);
    end
    tick();
    rst = 0; tick(); idle();
    checks++;
    if ({stat_branches, stat_mispredicts} !== 32'd0) begin
      errors++;
      $display("FAIL stats_rst got %h/%h exp 0/0",
               stat_branches, stat_mispredicts);
    end
  endtask
`endif

  initial begin
    foreach (bht[i]) bht[i] = 1;
    mpred = 0; m_br = 0; m_mp = 0;
    test_reset();
    test_predict_init();
    test_train();
    test_stall();
    test_jump();
    test_saturate();
    test_reset_mid();
    test_random();
`ifdef BP_STATS_EN
    test_stats_wrap();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_predict_ctrl.md
BRANCH_PREDICT_CTRL -- requirements
Module: branch_predict_ctrl

Interface
REQ-001 SHALL have parameter BHT_IDX_W, default 4, meaning log2 of branch-history-table entries (2^BHT_IDX_W 2-bit counters).
REQ-002 SHALL have parameter PC_W, default 32, meaning program-counter width.
REQ-003 SHALL have parameter CNT_INIT, default 2'b01, meaning reset value of every BHT counter (weakly not-taken).
REQ-004 SHALL have ports: clk in 1 clock; rst in 1 reset, synchronous and active-low.
REQ-005 SHALL have ports: if_pc in PC_W fetch PC; if_is_beq in 1 predecoded fetch instruction is beq.
REQ-006 SHALL have ports: id_valid in 1; id_opcode in 6; id_pc in PC_W; id_equal in 1 (Rdata1==Rdata2); id_rs in 5; id_rt in 5.
REQ-007 SHALL have ports: idex_memread in 1; idex_rt in 5 (load in EX, for load-use detect).
REQ-008 SHALL have ports: ctrl out 8, bit order [7:0] = RegDst, RegWrite, ALUSrc, ALUOp[1:0], MemWrite, MemRead, MemToReg.
REQ-009 SHALL have ports: sel_pc out 2 (00 PC+4, 01 predicted target, 10 jump target, 11 recovery); recover_taken out 1 (1 = recovery to branch target, 0 = to id_pc+4).
REQ-010 SHALL have ports: if_flush out 1; pc_write out 1; ifid_write out 1.
REQ-011 SHALL, under BP_STATS_EN only, have ports: stat_branches out 16; stat_mispredicts out 16.

Function
REQ-012 SHALL decode id_opcode combinationally: 000000 -> 11010000; 000010 -> 00111000; 000100 -> 00001000; 001000 -> 01100000; 100011 -> 01100011; 101011 -> 00100100; any other opcode, or id_valid=0 -> 00000000.
REQ-013 SHALL predict in IF: index = if_pc[BHT_IDX_W+1:2]; pred = if_is_beq & counter[index][1]; sel_pc=01 when pred=1 and no ID redirect or stall.
REQ-014 SHALL register pred into an IF/ID prediction bit (id_pred) on each clk where ifid_write=1; cleared to 0 when if_flush=1; held when ifid_write=0.
REQ-015 SHALL detect load-use stall: stall = id_valid & idex_memread & (idex_rt!=0) & (idex_rt==id_rs | idex_rt==id_rt).
REQ-016 SHALL on stall drive pc_write=0, ifid_write=0, ctrl=0, sel_pc=00, if_flush=0, and perform no BHT update; stall has priority over jump and branch resolution.
REQ-017 SHALL on jump in ID (no stall) drive sel_pc=10, if_flush=1, discarding any IF prediction that cycle.
REQ-018 SHALL resolve beq in ID (no stall): mispredict = (id_equal != id_pred); on mispredict sel_pc=11, recover_taken=id_equal, if_flush=1; otherwise no redirect from ID.
REQ-019 SHALL update the BHT at the index from id_pc on every resolved beq: taken -> increment, saturating at 3; not taken -> decrement, saturating at 0; write on clk edge.
REQ-020 SHALL return the pre-update counter value when the IF lookup and the ID update hit the same index in the same cycle.
REQ-021 SHALL give ID redirect (10/11) priority over IF prediction (01); default outputs are sel_pc=00, pc_write=1, ifid_write=1, if_flush=0, recover_taken=0.
REQ-022 SHALL keep all other outputs purely combinational, with zero-cycle latency from ID inputs.

Reset
REQ-023 SHALL, on clk edge with rst=0, set all BHT counters to CNT_INIT, set id_pred to 0, and clear statistics counters; rst dominates every other event, including mid-stall and mid-resolve.
REQ-024 SHALL leave combinational outputs decoded from current inputs during reset; after reset release, with id_valid=0, the outputs are ctrl=0 and sel_pc=00.

Configuration
REQ-025 SHALL, with BP_STATS_EN defined, increment stat_branches on each resolved beq and stat_mispredicts on each mispredict, both wrapping modulo 2^16.
REQ-026 SHALL, without BP_STATS_EN, omit both statistics ports and their registers.

Verification
REQ-027 Reset, then if_pc=0x40 with if_is_beq=1 -> pred=0 and sel_pc=00 (CNT_INIT=01).
REQ-028 Two beq at id_pc=0x40 with id_equal=1 -> first: sel_pc=11, recover_taken=1, if_flush=1; counter becomes 3; next IF lookup at 0x40 -> sel_pc=01.
REQ-029 idex_memread=1, idex_rt=5, ID beq with id_rs=5 -> pc_write=0, ifid_write=0, ctrl=0, counter unchanged; next cycle with idex_memread=0 -> beq resolves.
REQ-030 ID jump (opcode 000010) while IF predicts taken -> sel_pc=10, if_flush=1, id_pred=0 next cycle.
REQ-031 Counter at 0 with a not-taken beq -> stays 0; counter at 3 with a taken beq -> stays 3; same-index IF read that cycle returns the old value.
REQ-032 With BP_STATS_EN, after 0xFFFF mispredicts plus one more -> stat_mispredicts=0; rst=0 mid-run -> both statistics counters read 0.
